// File: rtl/mandel_scan_if.sv
// Bundle of scan control, configuration, datapath and pixel-stream signals
// shared between a host/datapath (master) and the scan controller (slave).
interface mandel_scan_if #(
    parameter int COORD_W = 8,
    parameter int ITER_W  = 8,
    parameter int DIM_W   = 6
);
    logic                scan_start;
    logic                scan_abort;
    logic [COORD_W-1:0]  cfg_x0;
    logic [COORD_W-1:0]  cfg_y0;
    logic [COORD_W-1:0]  cfg_dx;
    logic [COORD_W-1:0]  cfg_dy;
    logic [DIM_W-1:0]    cfg_w;
    logic [DIM_W-1:0]    cfg_h;
    logic [COORD_W-1:0]  core_cr;
    logic [COORD_W-1:0]  core_ci;
    logic                core_start;
    logic                core_done;
    logic [ITER_W-1:0]   core_iter;
    logic                pix_valid;
    logic                pix_ready;
    logic [ITER_W-1:0]   pix_iter;
    logic [DIM_W-1:0]    pix_x;
    logic [DIM_W-1:0]    pix_y;
    logic                pix_last;
    logic                busy;

    modport master (
        output scan_start, scan_abort, cfg_x0, cfg_y0, cfg_dx, cfg_dy, cfg_w, cfg_h,
        output core_done, core_iter, pix_ready,
        input  core_cr, core_ci, core_start, pix_valid, pix_iter, pix_x, pix_y,
        input  pix_last, busy
    );

    modport slave (
        input  scan_start, scan_abort, cfg_x0, cfg_y0, cfg_dx, cfg_dy, cfg_w, cfg_h,
        input  core_done, core_iter, pix_ready,
        output core_cr, core_ci, core_start, pix_valid, pix_iter, pix_x, pix_y,
        output pix_last, busy
    );
endinterface

// File: rtl/mandel_scan_ctrl.sv
// Row-major pixel scan sequencer for a Mandelbrot iteration datapath: issues
// one datapath job per pixel and streams the results out with backpressure.
module mandel_scan_ctrl #(
    parameter int COORD_W = 8,
    parameter int ITER_W  = 8,
    parameter int DIM_W   = 6
) (
    input logic           clk,
    input logic           rst,
    mandel_scan_if.slave  bus
);
    typedef enum logic [1:0] {IDLE, ISSUE, WAIT, EMIT} state_t;

    localparam logic [DIM_W-1:0] ONE_DIM = 1;

    state_t              r_state;
    logic [COORD_W-1:0]  r_x0;
    logic [COORD_W-1:0]  r_dx;
    logic [COORD_W-1:0]  r_dy;
    logic [DIM_W-1:0]    r_w;
    logic [DIM_W-1:0]    r_h;
    logic [DIM_W-1:0]    r_x;
    logic [DIM_W-1:0]    r_y;
    logic [COORD_W-1:0]  r_coreCr;
    logic [COORD_W-1:0]  r_coreCi;
    logic                r_coreStart;
    logic                r_pixValid;
    logic [ITER_W-1:0]   r_pixIter;
    logic [DIM_W-1:0]    r_pixX;
    logic [DIM_W-1:0]    r_pixY;
    logic                r_pixLast;
    logic                r_busy;
    logic                w_lastPix;

    assign w_lastPix = (r_x == r_w) && (r_y == r_h);

    // Abort takes priority over every other input once reset is released.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= IDLE;
            r_x0        <= '0;
            r_dx        <= '0;
            r_dy        <= '0;
            r_w         <= '0;
            r_h         <= '0;
            r_x         <= '0;
            r_y         <= '0;
            r_coreCr    <= '0;
            r_coreCi    <= '0;
            r_coreStart <= 1'b0;
            r_pixValid  <= 1'b0;
            r_pixIter   <= '0;
            r_pixX      <= '0;
            r_pixY      <= '0;
            r_pixLast   <= 1'b0;
            r_busy      <= 1'b0;
        end else if (bus.scan_abort) begin
            r_state     <= IDLE;
            r_coreStart <= 1'b0;
            r_pixValid  <= 1'b0;
            r_busy      <= 1'b0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (bus.scan_start) begin
                        r_x0        <= bus.cfg_x0;
                        r_dx        <= bus.cfg_dx;
                        r_dy        <= bus.cfg_dy;
                        r_w         <= bus.cfg_w;
                        r_h         <= bus.cfg_h;
                        r_x         <= '0;
                        r_y         <= '0;
                        r_coreCr    <= bus.cfg_x0;
                        r_coreCi    <= bus.cfg_y0;
                        r_coreStart <= 1'b1;
                        r_busy      <= 1'b1;
                        r_state     <= ISSUE;
                    end
                end
                ISSUE: begin
                    r_coreStart <= 1'b0;
                    r_state     <= WAIT;
                end
                WAIT: begin
                    if (bus.core_done) begin
                        r_pixIter  <= bus.core_iter;
                        r_pixX     <= r_x;
                        r_pixY     <= r_y;
                        r_pixLast  <= w_lastPix;
                        r_pixValid <= 1'b1;
                        r_state    <= EMIT;
                    end
                end
                EMIT: begin
                    if (bus.pix_ready) begin
                        r_pixValid <= 1'b0;
                        if (r_pixLast) begin
                            r_busy  <= 1'b0;
                            r_state <= IDLE;
                        end else begin
                            r_coreStart <= 1'b1;
                            r_state     <= ISSUE;
                            // End of a row returns Cr to the row origin and steps Ci.
                            if (r_x != r_w) begin
                                r_x      <= r_x + ONE_DIM;
                                r_coreCr <= r_coreCr + r_dx;
                            end else begin
                                r_x      <= '0;
                                r_y      <= r_y + ONE_DIM;
                                r_coreCr <= r_x0;
                                r_coreCi <= r_coreCi + r_dy;
                            end
                        end
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    assign bus.core_cr    = r_coreCr;
    assign bus.core_ci    = r_coreCi;
    assign bus.core_start = r_coreStart;
    assign bus.pix_valid  = r_pixValid;
    assign bus.pix_iter   = r_pixIter;
    assign bus.pix_x      = r_pixX;
    assign bus.pix_y      = r_pixY;
    assign bus.pix_last   = r_pixLast;
    assign bus.busy       = r_busy;
endmodule

// File: tb/tb_mandel_scan_ctrl.sv
// Self-checking bench for mandel_scan_ctrl: table-driven and randomized scans
// checked against an arithmetic pixel model, plus abort/reset corner sequences.
module tb_mandel_scan_ctrl;
    localparam int CW = 8;
    localparam int IW = 8;
    localparam int DW = 6;

    typedef struct {
        logic [7:0] x0;
        logic [7:0] dx;
        logic [7:0] y0;
        logic [7:0] dy;
        logic [5:0] w;
        logic [5:0] h;
        int         lat;
        int         stall;
        int         iterBase;
        bit         pulseStart;
        int         expCount;
        logic [7:0] expLastCr;
        logic [7:0] expLastCi;
    } scanVec_t;

    logic clk = 1'b0;
    logic rst;
    int   errCnt = 0;
    int   chkCnt = 0;

    always #5 clk = ~clk;

    mandel_scan_if #(.COORD_W(CW), .ITER_W(IW), .DIM_W(DW)) bus ();

    mandel_scan_ctrl #(.COORD_W(CW), .ITER_W(IW), .DIM_W(DW)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        chkCnt++;
        if (act !== exp) begin
            errCnt++;
            $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic idleInputs();
        bus.scan_start = 1'b0;
        bus.scan_abort = 1'b0;
        bus.core_done  = 1'b0;
        bus.core_iter  = '0;
        bus.pix_ready  = 1'b0;
        bus.cfg_x0     = '0;
        bus.cfg_y0     = '0;
        bus.cfg_dx     = '0;
        bus.cfg_dy     = '0;
        bus.cfg_w      = '0;
        bus.cfg_h      = '0;
    endtask

    task automatic checkAllZero(input string tag);
        checkOutput({tag, " core_cr"}, 32'(bus.core_cr), 32'h0);
        checkOutput({tag, " core_ci"}, 32'(bus.core_ci), 32'h0);
        checkOutput({tag, " core_start"}, 32'(bus.core_start), 32'h0);
        checkOutput({tag, " pix_valid"}, 32'(bus.pix_valid), 32'h0);
        checkOutput({tag, " pix_iter"}, 32'(bus.pix_iter), 32'h0);
        checkOutput({tag, " pix_x"}, 32'(bus.pix_x), 32'h0);
        checkOutput({tag, " pix_y"}, 32'(bus.pix_y), 32'h0);
        checkOutput({tag, " pix_last"}, 32'(bus.pix_last), 32'h0);
        checkOutput({tag, " busy"}, 32'(bus.busy), 32'h0);
    endtask

    function automatic scanVec_t mkVec(input logic [7:0] x0, input logic [7:0] dx,
                                       input logic [7:0] y0, input logic [7:0] dy,
                                       input logic [5:0] w, input logic [5:0] h,
                                       input int lat, input int stall, input int iterBase,
                                       input bit pulseStart, input int expCount,
                                       input logic [7:0] expLastCr, input logic [7:0] expLastCi);
        scanVec_t v;
        v.x0 = x0; v.dx = dx; v.y0 = y0; v.dy = dy; v.w = w; v.h = h;
        v.lat = lat; v.stall = stall; v.iterBase = iterBase; v.pulseStart = pulseStart;
        v.expCount = expCount; v.expLastCr = expLastCr; v.expLastCi = expLastCi;
        return v;
    endfunction

    // Runs one complete scan, acting as datapath and stream sink, checking every pixel.
    task automatic applyStimulus(input scanVec_t v);
        int         n;
        int         starts;
        int         stallCycles;
        int         px;
        int         py;
        logic [7:0] expCr;
        logic [7:0] expCi;
        logic [7:0] expIter;
        logic [7:0] lastCr;
        logic [7:0] lastCi;
        n      = (int'(v.w) + 1) * (int'(v.h) + 1);
        starts = 0;
        lastCr = '0;
        lastCi = '0;
        bus.cfg_x0 = v.x0; bus.cfg_dx = v.dx; bus.cfg_y0 = v.y0; bus.cfg_dy = v.dy;
        bus.cfg_w  = v.w;  bus.cfg_h  = v.h;
        bus.scan_start = 1'b1;
        tick();
        bus.scan_start = 1'b0;
        bus.cfg_x0 = 8'($urandom); bus.cfg_dx = 8'($urandom);
        bus.cfg_y0 = 8'($urandom); bus.cfg_dy = 8'($urandom);
        bus.cfg_w  = 6'($urandom); bus.cfg_h  = 6'($urandom);
        for (int k = 0; k < n; k++) begin
            px      = k % (int'(v.w) + 1);
            py      = k / (int'(v.w) + 1);
            expCr   = 8'(int'(v.x0) + px * int'(v.dx));
            expCi   = 8'(int'(v.y0) + py * int'(v.dy));
            expIter = 8'(v.iterBase + k);
            checkOutput("core_start pulse", 32'(bus.core_start), 32'h1);
            if (bus.core_start) starts++;
            checkOutput("core_cr", 32'(bus.core_cr), 32'(expCr));
            checkOutput("core_ci", 32'(bus.core_ci), 32'(expCi));
            checkOutput("busy in scan", 32'(bus.busy), 32'h1);
            lastCr = bus.core_cr;
            lastCi = bus.core_ci;
            bus.scan_start = v.pulseStart;
            bus.core_done  = ($urandom % 4) == 0;
            bus.core_iter  = 8'($urandom);
            for (int i = 0; i < v.lat; i++) begin
                tick();
                bus.core_done = 1'b0;
                checkOutput("core_start in wait", 32'(bus.core_start), 32'h0);
                if (bus.core_start) starts++;
                checkOutput("core_cr stable", 32'(bus.core_cr), 32'(expCr));
                checkOutput("core_ci stable", 32'(bus.core_ci), 32'(expCi));
                checkOutput("pix_valid in wait", 32'(bus.pix_valid), 32'h0);
            end
            bus.core_done = 1'b1;
            bus.core_iter = expIter;
            tick();
            bus.core_done = 1'b0;
            bus.core_iter = 8'($urandom);
            checkOutput("pix_valid", 32'(bus.pix_valid), 32'h1);
            checkOutput("pix_iter", 32'(bus.pix_iter), 32'(expIter));
            checkOutput("pix_x", 32'(bus.pix_x), 32'(px));
            checkOutput("pix_y", 32'(bus.pix_y), 32'(py));
            checkOutput("pix_last", 32'(bus.pix_last), (k == n - 1) ? 32'h1 : 32'h0);
            stallCycles = (v.stall < 0) ? int'($urandom_range(0, 3)) : v.stall;
            for (int s = 0; s < stallCycles; s++) begin
                bus.pix_ready = 1'b0;
                bus.core_done = ($urandom % 2) == 1;
                tick();
                checkOutput("pix_valid held", 32'(bus.pix_valid), 32'h1);
                checkOutput("pix_iter held", 32'(bus.pix_iter), 32'(expIter));
                checkOutput("pix_x held", 32'(bus.pix_x), 32'(px));
                checkOutput("pix_y held", 32'(bus.pix_y), 32'(py));
                checkOutput("core_start in emit", 32'(bus.core_start), 32'h0);
                if (bus.core_start) starts++;
            end
            bus.core_done = 1'b0;
            bus.pix_ready = 1'b1;
            tick();
            bus.pix_ready  = 1'b0;
            bus.scan_start = 1'b0;
            checkOutput("pix_valid drop", 32'(bus.pix_valid), 32'h0);
        end
        for (int i = 0; i < 3; i++) begin
            checkOutput("busy after scan", 32'(bus.busy), 32'h0);
            checkOutput("core_start after scan", 32'(bus.core_start), 32'h0);
            if (bus.core_start) starts++;
            tick();
        end
        checkOutput("core_start count", 32'(starts), 32'(v.expCount));
        checkOutput("last core_cr", 32'(lastCr), 32'(v.expLastCr));
        checkOutput("last core_ci", 32'(lastCi), 32'(v.expLastCi));
    endtask

    scanVec_t vecs[5];

    initial begin
        scanVec_t rv;
        vecs[0] = mkVec(8'hF8, 8'h04, 8'hFC, 8'h02, 6'd1, 6'd1, 3, 0, 10, 1'b0, 4, 8'hFC, 8'hFE);
        vecs[1] = mkVec(8'h7E, 8'h01, 8'h10, 8'h33, 6'd3, 6'd0, 1, 1, 20, 1'b0, 4, 8'h81, 8'h10);
        vecs[2] = mkVec(8'h20, 8'h08, 8'h40, 8'hF8, 6'd1, 6'd2, 2, 5, 40, 1'b0, 6, 8'h28, 8'h30);
        vecs[3] = mkVec(8'h10, 8'hF0, 8'h80, 8'h40, 6'd2, 6'd2, 2, -1, 60, 1'b0, 9, 8'hF0, 8'h00);
        vecs[4] = mkVec(8'h55, 8'h11, 8'hAA, 8'h22, 6'd0, 6'd0, 1, 2, 99, 1'b1, 1, 8'h55, 8'hAA);

        idleInputs();
        rst = 1'b1;
        bus.scan_start = 1'b1;
        bus.cfg_x0 = 8'h5A;
        tick();
        tick();
        checkAllZero("reset");
        rst = 1'b0;
        idleInputs();
        tick();
        checkOutput("idle busy", 32'(bus.busy), 32'h0);

        for (int t = 0; t < 5; t++) begin
            $display("[TB] table vector %0d", t);
            applyStimulus(vecs[t]);
        end

        for (int r = 0; r < 6; r++) begin
            rv.x0 = 8'($urandom); rv.dx = 8'($urandom);
            rv.y0 = 8'($urandom); rv.dy = 8'($urandom);
            rv.w  = 6'($urandom_range(0, 3)); rv.h = 6'($urandom_range(0, 3));
            rv.lat = int'($urandom_range(1, 4));
            rv.stall = -1;
            rv.iterBase = int'($urandom_range(0, 200));
            rv.pulseStart = ($urandom % 2) == 1;
            rv.expCount = (int'(rv.w) + 1) * (int'(rv.h) + 1);
            rv.expLastCr = 8'(int'(rv.x0) + int'(rv.w) * int'(rv.dx));
            rv.expLastCi = 8'(int'(rv.y0) + int'(rv.h) * int'(rv.dy));
            $display("[TB] random scan %0d w=%0d h=%0d", r, rv.w, rv.h);
            applyStimulus(rv);
        end

        // Abort while waiting on the datapath, then a late core_done.
        bus.cfg_x0 = 8'h11; bus.cfg_y0 = 8'h22; bus.cfg_w = 6'd1; bus.cfg_h = 6'd1;
        bus.scan_start = 1'b1;
        tick();
        bus.scan_start = 1'b0;
        checkOutput("abort seq core_start", 32'(bus.core_start), 32'h1);
        tick();
        bus.scan_abort = 1'b1;
        bus.core_done  = 1'b1;
        tick();
        bus.scan_abort = 1'b0;
        bus.core_done  = 1'b0;
        checkOutput("abort busy", 32'(bus.busy), 32'h0);
        checkOutput("abort pix_valid", 32'(bus.pix_valid), 32'h0);
        checkOutput("abort core_start", 32'(bus.core_start), 32'h0);
        tick();
        bus.core_done = 1'b1;
        bus.core_iter = 8'h3C;
        tick();
        bus.core_done = 1'b0;
        for (int i = 0; i < 5; i++) begin
            checkOutput("post-abort pix_valid", 32'(bus.pix_valid), 32'h0);
            checkOutput("post-abort core_start", 32'(bus.core_start), 32'h0);
            checkOutput("post-abort busy", 32'(bus.busy), 32'h0);
            tick();
        end

        // Reset while a pixel is being offered on the stream.
        bus.cfg_x0 = 8'h33; bus.cfg_y0 = 8'h44; bus.cfg_dx = 8'h01; bus.cfg_dy = 8'h01;
        bus.cfg_w = 6'd1; bus.cfg_h = 6'd1;
        bus.scan_start = 1'b1;
        tick();
        bus.scan_start = 1'b0;
        tick();
        bus.core_done = 1'b1;
        bus.core_iter = 8'h77;
        tick();
        bus.core_done = 1'b0;
        checkOutput("pre-reset pix_valid", 32'(bus.pix_valid), 32'h1);
        rst = 1'b1;
        bus.pix_ready = 1'b1;
        tick();
        rst = 1'b0;
        bus.pix_ready = 1'b0;
        checkAllZero("mid-scan reset");
        applyStimulus(vecs[0]);

        $display("Result: errors=%0d of %0d checks", errCnt, chkCnt);
        $finish;
    end
endmodule
